// File: rtl/pio_gpio_irq.sv
// Avalon-MM GPIO bank: per-pin data/direction with atomic set/clear, synchronised inputs,
// per-pin rising/falling edge capture and a maskable level interrupt.
module pio_gpio_irq #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             csi_MCLK_clk,
    input  logic             rsi_MRST_reset,
    input  logic [2:0]       avs_gpio_address,
    input  logic [31:0]      avs_gpio_writedata,
    input  logic [3:0]       avs_gpio_byteenable,
    input  logic             avs_gpio_write,
    input  logic             avs_gpio_read,
    output logic [31:0]      avs_gpio_readdata,
    output logic             avs_gpio_waitrequest,
    output logic             ins_gpio_irq,
    inout  wire  [WIDTH-1:0] coe_P
);

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_SET      = 3'd2;
    localparam logic [2:0] ADDR_CLR      = 3'd3;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd5;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd6;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd7;

    logic [WIDTH-1:0] out_q,     out_d;
    logic [WIDTH-1:0] dir_q,     dir_d;
    logic [WIDTH-1:0] mask_q,    mask_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] cap_q,     cap_d;
    logic [WIDTH-1:0] pin_d_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [31:0]      rdata_q,   rdata_d;
    logic             irq_q,     irq_d;

    logic [31:0]      wmask;
    logic [WIDTH-1:0] wsel;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] pin_s;
    logic [WIDTH-1:0] edge_det;
    logic             unused_bits;

    assign pin_s       = sync_q[SYNC_STAGES-1];
    assign unused_bits = ^{avs_gpio_writedata, wmask};

    for (genvar i = 0; i < WIDTH; i++) begin : g_pad
        assign coe_P[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_comb begin
        wmask    = {{8{avs_gpio_byteenable[3]}}, {8{avs_gpio_byteenable[2]}},
                    {8{avs_gpio_byteenable[1]}}, {8{avs_gpio_byteenable[0]}}};
        wsel     = wmask[WIDTH-1:0];
        wbits    = avs_gpio_writedata[WIDTH-1:0] & wsel;
        edge_det = (pin_s & ~pin_d_q & rise_en_q) | (~pin_s & pin_d_q & fall_en_q);

        out_d     = out_q;
        dir_d     = dir_q;
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        // new edges are OR'd in after the W1C so a same-cycle capture survives the clear
        cap_d     = cap_q | edge_det;

        if (avs_gpio_write) begin
            case (avs_gpio_address)
                ADDR_DATA:     out_d     = (out_q & ~wsel) | wbits;
                ADDR_DIR:      dir_d     = (dir_q & ~wsel) | wbits;
                ADDR_SET:      out_d     = out_q | wbits;
                ADDR_CLR:      out_d     = out_q & ~wbits;
                ADDR_IRQ_MASK: mask_d    = (mask_q & ~wsel) | wbits;
                ADDR_EDGE_CAP: cap_d     = (cap_q & ~wbits) | edge_det;
                ADDR_RISE_EN:  rise_en_d = (rise_en_q & ~wsel) | wbits;
                ADDR_FALL_EN:  fall_en_d = (fall_en_q & ~wsel) | wbits;
                default:       out_d     = out_q;
            endcase
        end

        irq_d   = |(cap_q & mask_q);

        rdata_d = '0;
        if (avs_gpio_read) begin
            case (avs_gpio_address)
                ADDR_DATA:     rdata_d[WIDTH-1:0] = pin_s;
                ADDR_DIR:      rdata_d[WIDTH-1:0] = dir_q;
                ADDR_SET:      rdata_d[WIDTH-1:0] = out_q;
                ADDR_CLR:      rdata_d[WIDTH-1:0] = out_q;
                ADDR_IRQ_MASK: rdata_d[WIDTH-1:0] = mask_q;
                ADDR_EDGE_CAP: rdata_d[WIDTH-1:0] = cap_q;
                ADDR_RISE_EN:  rdata_d[WIDTH-1:0] = rise_en_q;
                ADDR_FALL_EN:  rdata_d[WIDTH-1:0] = fall_en_q;
                default:       rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            out_q     <= OUT_RESET;
            dir_q     <= '0;
            mask_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            cap_q     <= '0;
            pin_d_q   <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            mask_q    <= mask_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            cap_q     <= cap_d;
            pin_d_q   <= pin_s;
            sync_q[0] <= coe_P;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign avs_gpio_readdata    = rdata_q;
    assign avs_gpio_waitrequest = 1'b0;
    assign ins_gpio_irq         = irq_q;

endmodule

// File: tb/tb_pio_gpio_irq.sv
// Directed bench for pio_gpio_irq (WIDTH=8, SYNC_STAGES=2, OUT_RESET=0x3C).
module tb_pio_gpio_irq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = 4'hF;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] rdata;
    logic        waitreq;
    logic        irq;
    wire  [7:0]  pins;
    logic [7:0]  ext_en = 8'hFF;
    logic [7:0]  ext_val = 8'h00;
    int          vectors = 0;
    int          miscompares = 0;

    for (genvar i = 0; i < 8; i++) begin : g_ext
        assign pins[i] = ext_en[i] ? ext_val[i] : 1'bz;
    end

    pio_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2), .OUT_RESET(8'h3C)) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_gpio_address     (address),
        .avs_gpio_writedata   (wdata),
        .avs_gpio_byteenable  (be),
        .avs_gpio_write       (wr),
        .avs_gpio_read        (rd),
        .avs_gpio_readdata    (rdata),
        .avs_gpio_waitrequest (waitreq),
        .ins_gpio_irq         (irq),
        .coe_P                (pins)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        address = a; wdata = d; be = b; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; be = 4'hF;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; ext_en = 8'hFF; ext_val = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (pins !== 8'h00) begin miscompares++; $display("FAIL reset_pins got=%h exp=%h", pins, 8'h00); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got=%b exp=0", irq); end
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        vectors++;
        if (waitreq !== 1'b0) begin miscompares++; $display("FAIL waitrequest got=%b exp=0", waitreq); end
        bus_read(3'd1, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL reset_dir got=%h exp=0", d); end
        bus_read(3'd2, d);
        vectors++;
        if (d !== 32'h3C) begin miscompares++; $display("FAIL reset_out_data got=%h exp=%h", d, 32'h3C); end
    endtask

    task automatic test_direction();
        logic [31:0] d;
        ext_en = 8'hF0; ext_val = 8'h30;
        bus_write(3'd1, 32'h0F, 4'hF);
        bus_write(3'd0, 32'hA5, 4'hF);
        vectors++;
        if (pins !== 8'h35) begin miscompares++; $display("FAIL dir_drive got=%h exp=%h", pins, 8'h35); end
        repeat (3) @(negedge clk);
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'h35) begin miscompares++; $display("FAIL dir_readback got=%h exp=%h", d, 32'h35); end
        bus_read(3'd2, d);
        vectors++;
        if (d !== 32'hA5) begin miscompares++; $display("FAIL dir_out_data got=%h exp=%h", d, 32'hA5); end
    endtask

    task automatic test_set_clear();
        logic [31:0] d;
        bus_write(3'd0, 32'h00, 4'hF);
        bus_write(3'd2, 32'h81, 4'hF);
        bus_write(3'd3, 32'h01, 4'hF);
        bus_read(3'd2, d);
        vectors++;
        if (d !== 32'h80) begin miscompares++; $display("FAIL set_clr got=%h exp=%h", d, 32'h80); end
        bus_write(3'd0, 32'hFF, 4'b0010);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h80) begin miscompares++; $display("FAIL be_lane_off got=%h exp=%h", d, 32'h80); end
        bus_write(3'd2, 32'hFFFF_FF7F, 4'hF);
        bus_read(3'd2, d);
        vectors++;
        if (d !== 32'hFF) begin miscompares++; $display("FAIL set_upper_ignored got=%h exp=%h", d, 32'hFF); end
        bus_write(3'd3, 32'h0F, 4'b0000);
        bus_write(3'd3, 32'hF0, 4'b0001);
        bus_read(3'd3, d);
        vectors++;
        if (d !== 32'h0F) begin miscompares++; $display("FAIL clr_be got=%h exp=%h", d, 32'h0F); end
        repeat (2) @(negedge clk);
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'h3F) begin miscompares++; $display("FAIL loopback got=%h exp=%h", d, 32'h3F); end
        bus_write(3'd1, 32'h00, 4'hF);
        ext_en = 8'hFF; ext_val = 8'h00;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_rise_irq();
        bus_write(3'd6, 32'h01, 4'hF);
        bus_write(3'd4, 32'h01, 4'hF);
        repeat (2) @(negedge clk);
        ext_val[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        address = 3'd5; rd = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdata !== 32'h00) begin miscompares++; $display("FAIL cap_early got=%h exp=0", rdata); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(negedge clk);
        rd = 1'b0;
        vectors++;
        if (rdata !== 32'h01) begin miscompares++; $display("FAIL cap_at_3 got=%h exp=%h", rdata, 32'h01); end
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_at_4 got=%b exp=1", irq); end
        bus_write(3'd5, 32'h01, 4'hF);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_hold_w1c got=%b exp=1", irq); end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_masked_both();
        logic [31:0] d;
        bus_write(3'd6, 32'h04, 4'hF);
        bus_write(3'd7, 32'h04, 4'hF);
        bus_write(3'd4, 32'h00, 4'hF);
        ext_val[2] = 1'b1;
        repeat (5) @(negedge clk);
        bus_read(3'd5, d);
        vectors++;
        if (d !== 32'h04) begin miscompares++; $display("FAIL rise_cap_p2 got=%h exp=%h", d, 32'h04); end
        bus_write(3'd5, 32'h04, 4'hF);
        ext_val[2] = 1'b0;
        repeat (5) @(negedge clk);
        bus_read(3'd5, d);
        vectors++;
        if (d !== 32'h04) begin miscompares++; $display("FAIL fall_cap_p2 got=%h exp=%h", d, 32'h04); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_masked got=%b exp=0", irq); end
        bus_write(3'd7, 32'h00, 4'hF);
        bus_read(3'd5, d);
        vectors++;
        if (d !== 32'h04) begin miscompares++; $display("FAIL en_write_keeps_cap got=%h exp=%h", d, 32'h04); end
        bus_write(3'd4, 32'h04, 4'hF);
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_unmask_early got=%b exp=0", irq); end
        @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_unmask got=%b exp=1", irq); end
        bus_write(3'd5, 32'h04, 4'hF);
        bus_write(3'd4, 32'h00, 4'hF);
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        bus_write(3'd6, 32'h01, 4'hF);
        bus_write(3'd4, 32'h01, 4'hF);
        ext_val[0] = 1'b0;
        repeat (4) @(negedge clk);
        ext_val[0] = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_pending got=%b exp=1", irq); end
        ext_val[0] = 1'b0;
        repeat (4) @(negedge clk);
        ext_val[0] = 1'b1;
        @(negedge clk);
        bus_write(3'd5, 32'h01, 4'hF);
        bus_read(3'd5, d);
        vectors++;
        if (d !== 32'h01) begin miscompares++; $display("FAIL set_wins_cap got=%h exp=%h", d, 32'h01); end
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL set_wins_irq got=%b exp=1", irq); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [2:0]  addr_tab [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [31:0] exp_tab  [7] = '{32'h0, 32'h3C, 32'h3C, 32'h0, 32'h0, 32'h0, 32'h0};
        bus_write(3'd7, 32'h10, 4'hF);
        ext_en = 8'h00;
        bus_write(3'd1, 32'hFF, 4'hF);
        bus_write(3'd0, 32'h5A, 4'hF);
        vectors++;
        if (pins !== 8'h5A) begin miscompares++; $display("FAIL drive_all got=%h exp=%h", pins, 8'h5A); end
        vectors++;
        if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_before_reset got=%b exp=1", irq); end
        address = 3'd1; rd = 1'b1;
        @(negedge clk);
        vectors++;
        if (rdata !== 32'hFF) begin miscompares++; $display("FAIL read_dir got=%h exp=%h", rdata, 32'hFF); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rd = 1'b0;
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL mid_reset_rdata got=%h exp=0", rdata); end
        vectors++;
        if (irq !== 1'b0) begin miscompares++; $display("FAIL mid_reset_irq got=%b exp=0", irq); end
        ext_en = 8'hFF; ext_val = 8'h00;
        #1;
        vectors++;
        if (pins !== 8'h00) begin miscompares++; $display("FAIL mid_reset_pins got=%h exp=0", pins); end
        for (int k = 0; k < 7; k++) begin
            bus_read(addr_tab[k], d);
            vectors++;
            if (d !== exp_tab[k]) begin
                miscompares++;
                $display("FAIL mid_reset_reg%0d got=%h exp=%h", addr_tab[k], d, exp_tab[k]);
            end
        end
        bus_read(3'd0, d);
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL mid_reset_data got=%h exp=0", d); end
        @(negedge clk);
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("FAIL idle_rdata got=%h exp=0", rdata); end
    endtask

    initial begin
        test_reset();
        test_direction();
        test_set_clear();
        test_rise_irq();
        test_masked_both();
        test_set_wins();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
